mssv_scroller: RTL

Upstream stage of the TM1638 display driver. Holds a ring of hex digits (student ID plus blank padding) and scrolls an 8-digit window across it at a programmable rate. Drives the driver's `seg7..seg0` nibble inputs and its `led` byte. All outputs are registered, so the driver's asynchronous frame sampling always sees a stable, consistent window.

---
 rtl/mssv_scroller_if.sv | 14 +
 rtl/mssv_scroller.sv | 102 ++++++++++
 2 files changed

// File: rtl/mssv_scroller_if.sv
// mssv_scroller_if: ring load/control inputs and window/led/wrap outputs of the scroller
interface mssv_scroller_if #(parameter int LEN = 16);
  logic [4*LEN-1:0] mssv;
  logic             load;
  logic             run;
  logic             dir;
  logic [3:0]       seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0;
  logic [7:0]       led;
  logic             wrap;
  modport master (output mssv, load, run, dir,
                  input  seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0, led, wrap);
  modport slave  (input  mssv, load, run, dir,
                  output seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0, led, wrap);
endinterface

// File: rtl/mssv_scroller.sv
// mssv_scroller: scrolls an 8-digit window over a ring of nibbles; optional paused blink via MSSV_BLINK_EN
module mssv_scroller #(
  parameter int LEN        = 16,
  parameter int STEP_TICKS = 6000000
) (
  input  logic           clkinput,
  input  logic           rst_n,
  mssv_scroller_if.slave bus
);
  localparam int              PW     = $clog2(LEN);
  localparam int              CW     = $clog2(STEP_TICKS);
  localparam logic [PW-1:0]   P_LAST = PW'(LEN - 1);
  localparam logic [CW-1:0]   C_LAST = CW'(STEP_TICKS - 1);
  logic [3:0]    r_ring [LEN];
  logic [PW-1:0] r_ptr;
  logic [CW-1:0] r_cnt;
  logic          r_wrap_p;
  logic          r_wrap;
  logic [3:0]    r_seg [8];
  logic [7:0]    r_led;
  logic          w_tick;
  logic          w_step;
  logic          w_wrap;
  logic          w_blank;
  logic [PW-1:0] w_ptr_nxt;
  logic [PW:0]   w_sum [8];
  logic [PW-1:0] w_idx [8];
  logic [3:0]    w_win [8];
  assign w_tick    = r_cnt == C_LAST;
  assign w_step    = bus.run && w_tick;
  assign w_wrap    = bus.dir ? r_ptr == '0 : r_ptr == P_LAST;
  assign w_ptr_nxt = w_wrap ? (bus.dir ? P_LAST : '0) : (bus.dir ? r_ptr - 1'b1 : r_ptr + 1'b1);
  // window slot indices: ptr+7-K folded back into the ring by a single compare-and-subtract
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      w_sum[k] = {1'b0, r_ptr} + (PW+1)'(7 - k);
      w_idx[k] = PW'(w_sum[k] >= (PW+1)'(LEN) ? w_sum[k] - (PW+1)'(LEN) : w_sum[k]);
      w_win[k] = r_ring[w_idx[k]];
    end
  end
  // ring, pointer and prescaler; load wins over a coincident step
  always_ff @(posedge clkinput or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LEN; i++) r_ring[i] <= 4'hF;
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (bus.load) begin
      for (int i = 0; i < LEN; i++) r_ring[i] <= bus.mssv[4*i +: 4];
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (bus.run) begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) r_ptr <= w_ptr_nxt;
    end
  end
`ifdef MSSV_BLINK_EN
  logic [CW-1:0] r_bcnt;
  logic          r_phase;
  logic          w_phase_nxt;
  assign w_phase_nxt = (bus.load || bus.run) ? 1'b0 : (r_bcnt == C_LAST) ? ~r_phase : r_phase;
  assign w_blank     = w_phase_nxt;
  // blink phase runs only while paused; its own counter keeps the scroll count untouched
  always_ff @(posedge clkinput or negedge rst_n) begin
    if (!rst_n) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else if (bus.load || bus.run) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else begin
      r_bcnt  <= r_bcnt == C_LAST ? '0 : r_bcnt + 1'b1;
      r_phase <= w_phase_nxt;
    end
  end
`else
  assign w_blank = 1'b0;
`endif
  // output stage: window, marker and wrap all move together one edge after the state
  always_ff @(posedge clkinput or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) r_seg[k] <= 4'hF;
      r_led    <= 8'h01;
      r_wrap_p <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      for (int k = 0; k < 8; k++) r_seg[k] <= w_blank ? 4'hF : w_win[k];
      r_led    <= 8'h01 << r_ptr[2:0];
      r_wrap_p <= !bus.load && w_step && w_wrap;
      r_wrap   <= !bus.load && r_wrap_p;
    end
  end
  assign bus.seg7 = r_seg[7];
  assign bus.seg6 = r_seg[6];
  assign bus.seg5 = r_seg[5];
  assign bus.seg4 = r_seg[4];
  assign bus.seg3 = r_seg[3];
  assign bus.seg2 = r_seg[2];
  assign bus.seg1 = r_seg[1];
  assign bus.seg0 = r_seg[0];
  assign bus.led  = r_led;
  assign bus.wrap = r_wrap;
endmodule
